// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared fully-connected layer sizes and weight loader state encoding
package fc_pkg;

    localparam int FC_DATA_WIDTH = 32;
    localparam int FC1_NODES     = 120;
    localparam int FC2_NODES     = 84;
    localparam int FC3_NODES     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_weight_loader_if.sv
// rtl/fc_weight_loader_if.sv - weight stream in, row write strobe out
interface fc_weight_loader_if
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int OUTPUT_NODES = FC2_NODES
) ();

    logic [DATA_WIDTH-1:0]              s_data;
    logic                               s_valid;
    logic                               s_last;
    logic                               s_ready;
    logic                               wr_en;
    logic [7:0]                         wr_addr;
    logic [OUTPUT_NODES*DATA_WIDTH-1:0] wr_row;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, wr_en, wr_addr, wr_row
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, wr_en, wr_addr, wr_row
    );

endinterface

// File: rtl/fc_row_buffer.sv
// rtl/fc_row_buffer.sv - one weight row, written a word at a time, read in parallel
module fc_row_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 84,
    parameter int IDX_W      = 7
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic [DEPTH*DATA_WIDTH-1:0] row_o
);

    // Unreset: every word is rewritten before the row can be committed.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

    assign row_o = mem_q;

endmodule

// File: rtl/fc_weight_loader.sv
// rtl/fc_weight_loader.sv - assembles a row-major weight stream into row writes
module fc_weight_loader
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int INPUT_NODES  = FC1_NODES,
    parameter int OUTPUT_NODES = FC2_NODES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    fc_weight_loader_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int RW = cnt_width(INPUT_NODES);
    localparam int CW = cnt_width(OUTPUT_NODES);
    localparam logic [RW-1:0] ROW_LAST = RW'(INPUT_NODES - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUTPUT_NODES - 1);

    loader_state_e                      state_q, state_d;
    logic [RW-1:0]                      row_q, row_d;
    logic [CW-1:0]                      col_q, col_d;
    logic                               last_ok_q, last_ok_d;
    logic [7:0]                         wr_addr_q;
    logic [OUTPUT_NODES*DATA_WIDTH-1:0] wr_row_q;
    logic [OUTPUT_NODES*DATA_WIDTH-1:0] buf_row;
    logic                               accept;
    logic                               commit;
    logic                               is_final;

    assign accept   = (state_q == ST_LOAD) && bus.s_valid;
    assign commit   = (state_q == ST_COMMIT);
    assign is_final = (row_q == ROW_LAST) && (col_q == COL_LAST);

    fc_row_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUTPUT_NODES),
        .IDX_W      (CW)
    ) u_row_buffer (
        .clk    (clk),
        .we_i   (accept),
        .idx_i  (col_q),
        .data_i (bus.s_data),
        .row_o  (buf_row)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            last_ok_q <= 1'b0;
            wr_addr_q <= '0;
            wr_row_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_ok_q <= last_ok_d;
            if (commit) begin
                wr_addr_q <= 8'(row_q);
                wr_row_q  <= buf_row;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        last_ok_d = last_ok_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    row_d     = '0;
                    col_d     = '0;
                    last_ok_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    col_d = col_q + 1'b1;
                    if (is_final) begin
                        last_ok_d = bus.s_last;
                    end
                    // A premature s_last abandons the row without committing it.
                    if (bus.s_last && !is_final) begin
                        state_d = ST_ERR;
                    end else if (col_q == COL_LAST) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                col_d = '0;
                row_d = row_q + 1'b1;
                if (row_q == ROW_LAST) begin
                    state_d = last_ok_q ? ST_DONE : ST_ERR;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.s_ready = (state_q == ST_LOAD);
    assign bus.wr_en   = commit;
    assign bus.wr_addr = commit ? 8'(row_q) : wr_addr_q;
    assign bus.wr_row  = commit ? buf_row : wr_row_q;
    assign busy        = (state_q == ST_LOAD) || commit;
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);

endmodule

// File: tb/tb_fc_weight_loader.sv
// tb/tb_fc_weight_loader.sv - directed self-checking bench for fc_weight_loader
module tb_fc_weight_loader;
    import fc_pkg::*;

    localparam int IN = 3;
    localparam int ON = 4;
    localparam int DW = 32;
    localparam int BIG_WORDS = FC1_NODES * FC2_NODES;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, err, busy2, done2, err2;

    always #5 clk = ~clk;

    fc_weight_loader_if #(.DATA_WIDTH(DW), .OUTPUT_NODES(ON)) bus ();
    fc_weight_loader_if bus2 ();

    fc_weight_loader #(.DATA_WIDTH(DW), .INPUT_NODES(IN), .OUTPUT_NODES(ON)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
        .busy(busy), .done(done), .err(err)
    );

    fc_weight_loader dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(bus2.slave),
        .busy(busy2), .done(done2), .err(err2)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int wr_addr_log[$];
    logic [ON*DW-1:0] wr_row_log[$];
    int wr_cyc[$];
    int acc_cyc[$];
    int done_cyc = -1;
    logic done_prev = 1'b0;
    int ready_in_commit = 0;
    int d_count = 0;
    int d_bad = 0;
    int d_last_addr = -1;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_addr_log.push_back(int'(bus.wr_addr));
            wr_row_log.push_back(bus.wr_row);
            wr_cyc.push_back(cycle);
            if (bus.s_ready !== 1'b0) ready_in_commit++;
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cycle;
        done_prev = done;
        if (bus2.wr_en === 1'b1) begin
            if (int'(bus2.wr_addr) != d_count) d_bad++;
            for (int j = 0; j < FC2_NODES; j++)
                if (bus2.wr_row[j*FC_DATA_WIDTH +: FC_DATA_WIDTH] !== (32'(d_count * FC2_NODES + j) ^ 32'hA5A50000))
                    d_bad++;
            d_last_addr = int'(bus2.wr_addr);
            d_count++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_row_log.delete();
        wr_cyc.delete();
        acc_cyc.delete();
        done_cyc = -1;
        ready_in_commit = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic drive(input int n, input int last_k, input bit toggle, input string name);
        int k = 0;
        int t = 0;
        while (k < n && t < 200) begin
            @(negedge clk);
            bus.s_valid = toggle ? ~t[0] : 1'b1;
            bus.s_data  = 32'h3F800000 + 32'(k);
            bus.s_last  = (k == last_k);
            if (bus.s_valid && bus.s_ready === 1'b1) begin
                acc_cyc.push_back(cycle);
                k++;
            end
            t++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        checks++;
        if (k != n) begin
            failures++;
            $display("FAIL %s_accepted got=%0d want=%0d", name, k, n);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, err, bus.s_ready, bus.wr_en} !== 5'b0 || bus.wr_addr !== 8'd0 || bus.wr_row !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b rdy=%b wr_en=%b addr=%0d", busy, done, err, bus.s_ready, bus.wr_en, bus.wr_addr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_load(input bit toggle, input string name);
        logic [ON*DW-1:0] exp_row;
        clear_logs();
        pulse_start();
        drive(IN * ON, IN * ON - 1, toggle, name);
        wait_cycles(2);
        checks++;
        if (wr_addr_log.size() != IN) begin
            failures++;
            $display("FAIL %s_write_count got=%0d want=%0d", name, wr_addr_log.size(), IN);
        end
        for (int r = 0; r < IN && r < wr_addr_log.size(); r++) begin
            for (int j = 0; j < ON; j++) exp_row[j*DW +: DW] = 32'h3F800000 + 32'(r * ON + j);
            checks++;
            if (wr_addr_log[r] != r || wr_row_log[r] !== exp_row) begin
                failures++;
                $display("FAIL %s_row%0d got addr=%0d row=%h want addr=%0d row=%h", name, r, wr_addr_log[r], wr_row_log[r], r, exp_row);
            end
            checks++;
            if (acc_cyc.size() > r * ON + ON - 1 && wr_cyc[r] != acc_cyc[r*ON + ON - 1] + 1) begin
                failures++;
                $display("FAIL %s_commit_latency%0d got=%0d want=%0d", name, r, wr_cyc[r], acc_cyc[r*ON + ON - 1] + 1);
            end
        end
        checks++;
        if (wr_cyc.size() == IN && done_cyc != wr_cyc[IN-1] + 1) begin
            failures++;
            $display("FAIL %s_done_latency got=%0d want=%0d", name, done_cyc, wr_cyc[IN-1] + 1);
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || ready_in_commit != 0) begin
            failures++;
            $display("FAIL %s_final_flags got done=%b err=%b busy=%b rdy_commit=%0d want 1 0 0 0", name, done, err, busy, ready_in_commit);
        end
    endtask

    task automatic test_early_last();
        clear_logs();
        pulse_start();
        drive(6, 5, 1'b0, "early_last");
        #2;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL early_last_err_edge got err=%b busy=%b rdy=%b want 1 0 0", err, busy, bus.s_ready);
        end
        wait_cycles(3);
        checks++;
        if (wr_addr_log.size() != 1 || wr_addr_log[0] != 0 || done !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL early_last_writes got count=%0d done=%b err=%b want 1 0 1", wr_addr_log.size(), done, err);
        end
    endtask

    task automatic test_missing_last();
        clear_logs();
        pulse_start();
        drive(IN * ON, -1, 1'b0, "missing_last");
        wait_cycles(3);
        checks++;
        if (wr_addr_log.size() != IN || wr_addr_log[IN-1] != IN - 1) begin
            failures++;
            $display("FAIL missing_last_writes got count=%0d want=%0d", wr_addr_log.size(), IN);
        end
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || done_cyc != -1) begin
            failures++;
            $display("FAIL missing_last_flags got err=%b done=%b done_cyc=%0d want 1 0 -1", err, done, done_cyc);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        pulse_start();
        drive(6, -1, 1'b0, "reset_mid");
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, bus.s_ready, bus.wr_en} !== 5'b0 || bus.wr_addr !== 8'd0 || bus.wr_row !== '0) begin
            failures++;
            $display("FAIL reset_async got busy=%b rdy=%b wr_en=%b row=%h want all 0", busy, bus.s_ready, bus.wr_en, bus.wr_row);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);
        checks++;
        if (wr_addr_log.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_writes got=%0d want=1", wr_addr_log.size());
        end
    endtask

    task automatic test_default_params();
        int k = 0;
        int t = 0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (k < BIG_WORDS && t < 12000) begin
            @(negedge clk);
            bus2.s_valid = 1'b1;
            bus2.s_data  = 32'(k) ^ 32'hA5A50000;
            bus2.s_last  = (k == BIG_WORDS - 1);
            if (bus2.s_ready === 1'b1) k++;
            t++;
        end
        @(negedge clk);
        bus2.s_valid = 1'b0;
        bus2.s_last  = 1'b0;
        wait_cycles(3);
        checks++;
        if (k != BIG_WORDS || d_count != FC1_NODES || d_last_addr != FC1_NODES - 1) begin
            failures++;
            $display("FAIL default_writes got words=%0d writes=%0d last_addr=%0d want %0d %0d %0d", k, d_count, d_last_addr, BIG_WORDS, FC1_NODES, FC1_NODES - 1);
        end
        checks++;
        if (d_bad != 0 || done2 !== 1'b1 || err2 !== 1'b0) begin
            failures++;
            $display("FAIL default_data got bad=%0d done=%b err=%b want 0 1 0", d_bad, done2, err2);
        end
    endtask

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
        bus.s_data   = '0;
        bus2.s_valid = 1'b0;
        bus2.s_last  = 1'b0;
        bus2.s_data  = '0;
        test_reset();
        test_full_load(1'b0, "full");
        test_full_load(1'b1, "toggle");
        test_early_last();
        test_full_load(1'b0, "reload_after_err");
        test_missing_last();
        test_reset_mid_load();
        test_full_load(1'b0, "reload_after_reset");
        test_default_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_weight_loader.md
FC_WEIGHT_LOADER -- requirements
Module: fc_weight_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one IEEE-754 single-precision weight word.
REQ-002 Parameter INPUT_NODES, default 120, number of rows (addresses) to load.
REQ-003 Parameter OUTPUT_NODES, default 84, number of weight words per row.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
REQ-007 s_data  input  DATA_WIDTH  streamed weight word.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_last  input  1  marks the final word of the whole matrix.
REQ-010 s_ready  output  1  loader accepts a word this cycle.
REQ-011 wr_en  output  1  one-cycle row write strobe to the weight memory.
REQ-012 wr_addr  output  8  row address, 0..INPUT_NODES-1.
REQ-013 wr_row  output  OUTPUT_NODES*DATA_WIDTH  packed row; word j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-014 busy  output  1  high in LOAD or COMMIT.
REQ-015 done  output  1  high in DONE.
REQ-016 err  output  1  high in ERR.

Function
REQ-017 Stream order is row-major: row 0 first; within a row, output node 0 first; a word is accepted only when s_valid and s_ready are both high.
REQ-018 FSM states IDLE, LOAD, COMMIT, DONE, ERR; the reset state is IDLE.
REQ-019 IDLE/DONE/ERR -> LOAD on start; row and column counters cleared to 0, done and err cleared on the same edge.
REQ-020 s_ready is 1 only in LOAD; the loader inserts no extra wait cycles in LOAD.
REQ-021 Each accepted word is stored at the column index, then the column counter increments; the accepted word with column OUTPUT_NODES-1 moves the FSM to COMMIT.
REQ-022 COMMIT lasts exactly one cycle: wr_en=1, wr_addr=row, wr_row=the complete buffer, s_ready=0.
REQ-023 After COMMIT, the row increments and the column clears; the FSM moves to DONE if the committed row was INPUT_NODES-1, otherwise back to LOAD.
REQ-024 Latency: wr_en rises the cycle after the last word of a row is accepted; done rises the cycle after the final COMMIT.
REQ-025 s_last on any accepted word other than the final one (row INPUT_NODES-1, column OUTPUT_NODES-1) -> ERR on the next edge, and that word is not committed.
REQ-026 Final word accepted without s_last -> the final COMMIT still occurs, then ERR instead of DONE.
REQ-027 start in LOAD or COMMIT is ignored; s_valid outside LOAD is ignored and causes no state change.
REQ-028 wr_addr and wr_row hold their last committed values outside COMMIT; wr_en is 0 outside COMMIT.
REQ-029 Data is passed bit-exact; the loader performs no arithmetic or format checking on words.

Reset
REQ-030 Asynchronous assertion of reset forces IDLE immediately, including mid-row or during COMMIT.
REQ-031 Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_row=0, busy=0, done=0, err=0, counters=0.
REQ-032 A partially loaded row is discarded on reset and is never written.

Structure
REQ-033 Shared package fc_pkg holds DATA_WIDTH, the layer sizes (120, 84, 10) and the loader state enum.
REQ-034 The row storage is one sub-module, fc_row_buffer (OUTPUT_NODES x DATA_WIDTH, indexed write, full-width parallel read).
REQ-035 Counters are sized with $clog2 of their parameter, minimum 1 bit; wr_addr is zero-extended to 8 bits.

Verification (INPUT_NODES=3, OUTPUT_NODES=4 unless stated)
REQ-036 Start, then 12 words 0x3F800000+k with s_last on k=11 and s_valid always high -> three wr_en pulses at addresses 0,1,2, each with the correct four packed words; done=1 one cycle after the third pulse.
REQ-037 The same stream with s_valid toggling 1/0 every cycle -> identical writes, with each row committed only after its fourth accepted word.
REQ-038 s_last asserted on word k=5 -> err=1 on the next edge; only the address-0 write occurs; start then reloads successfully.
REQ-039 Final word sent without s_last -> the address-2 write occurs, then err=1 and done=0.
REQ-040 reset asserted after 6 accepted words -> all outputs 0 asynchronously; a restarted full load yields exactly three writes starting at address 0.
REQ-041 Default parameters: 10080 words -> 120 writes at addresses 0..119, each 2688 bits wide; done=1.
